// File: rtl/mux_tree_pkg.sv
// Shared definitions for the pipelined mux tree: stage control record,
// elaboration limits and a clog2 helper that never returns 0.
package mux_tree_pkg;

  localparam int MUX_TREE_MAX_N = 64;

  typedef struct packed {
    logic valid;
    logic err;
  } stage_ctrl_t;

  // Select/level count for an n-input tree; a 2-input tree still needs one level.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_tree_level.sv
// One tree level: a row of 2:1 muxes steered by the low select bit, one register
// slice and its valid/ready advance logic. Err flops exist only with MUX_TREE_PIPE_SEL_ERR_EN.
module mux_tree_level
  import mux_tree_pkg::*;
#(
  parameter int W      = 8,
  parameter int N_CAND = 2,
  parameter int SW     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  stage_ctrl_t             in_ctrl,
  output logic                    in_ready,
  input  logic [N_CAND*W-1:0]     in_data,
  input  logic [SW-1:0]           in_sel,
  output stage_ctrl_t             out_ctrl,
  input  logic                    out_ready,
  output logic [(N_CAND/2)*W-1:0] out_data,
  output logic [SW-1:0]           out_sel
);

  localparam int N_OUT = N_CAND / 2;

  logic                 advance;
  logic                 load;
  logic [N_OUT*W-1:0]   mux_d;
  logic                 vld_p0;
  logic [N_OUT*W-1:0]   data_p0;
  logic [SW-1:0]        sel_p0;

  // A slice accepts when empty or when its current beat leaves in the same cycle.
  assign advance  = vld_p0 && out_ready;
  assign in_ready = !vld_p0 || advance;
  assign load     = in_ctrl.valid && in_ready;

  always_comb begin
    mux_d = '0;
    for (int i = 0; i < N_OUT; i++) begin
      mux_d[i*W +: W] = in_sel[0] ? in_data[(2*i+1)*W +: W] : in_data[(2*i)*W +: W];
    end
  end

  // ---- stage register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= mux_d;
      sel_p0  <= in_sel >> 1;
    end else if (advance) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_data = data_p0;
  assign out_sel  = sel_p0;

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
  logic err_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p0 <= 1'b0;
    end else if (load) begin
      err_p0 <= in_ctrl.err;
    end
  end

  assign out_ctrl = '{valid: vld_p0, err: err_p0};
`else
  logic unused_err;
  assign unused_err = in_ctrl.err;
  assign out_ctrl   = '{valid: vld_p0, err: 1'b0};
`endif

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN-to-1 mux tree with valid/ready on both sides, one register per level.
// Define MUX_TREE_PIPE_SEL_ERR_EN to flag beats whose select is out of range on out_err.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 8,
  parameter int SW   = clog2_min1(N_IN),
  parameter int L    = clog2_min1(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [SW-1:0]     in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_err
);

  localparam int NP        = 1 << L;
  localparam int BUS_WORDS = 2 * NP - 1;

  if (N_IN < 2) begin : g_chk_min
    $error("mux_tree_pipe: N_IN must be at least 2");
  end
  if (N_IN > MUX_TREE_MAX_N) begin : g_chk_max
    $error("mux_tree_pipe: N_IN exceeds MUX_TREE_MAX_N");
  end
  if (W < 1) begin : g_chk_w
    $error("mux_tree_pipe: W must be at least 1");
  end
  if (SW != clog2_min1(N_IN) || L != clog2_min1(N_IN)) begin : g_chk_derived
    $error("mux_tree_pipe: SW and L are derived from N_IN and must not be overridden");
  end

  // Word offset of the candidate set entering level k; all boundaries share one flat bus.
  function automatic int bnd_off(input int k);
    return 2 * NP - 2 * (NP >> k);
  endfunction

  logic [BUS_WORDS*W-1:0] data_bus;
  logic [(L+1)*SW-1:0]    sel_bus;
  stage_ctrl_t            ctrl_bus [0:L];
  logic [L:0]             rdy_bus;
  logic                   sel_err;
  logic                   unused_sel;

  // Leaves beyond N_IN read as zero, so an out-of-range select forwards 0.
  assign data_bus[0 +: NP*W] = (NP*W)'(in_data);
  assign sel_bus[0 +: SW]    = in_sel;
  assign ctrl_bus[0]         = '{valid: in_valid, err: sel_err};
  assign rdy_bus[L]          = out_ready;
  assign in_ready            = rdy_bus[0];

`ifdef MUX_TREE_PIPE_SEL_ERR_EN
  if (NP != N_IN) begin : g_err
    assign sel_err = (in_sel >= SW'(N_IN));
  end else begin : g_no_err
    assign sel_err = 1'b0;
  end
`else
  assign sel_err = 1'b0;
`endif

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NC      = NP >> k;
    localparam int OFF_IN  = bnd_off(k);
    localparam int OFF_OUT = bnd_off(k + 1);

    mux_tree_level #(
      .W      (W),
      .N_CAND (NC),
      .SW     (SW)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_ctrl   (ctrl_bus[k]),
      .in_ready  (rdy_bus[k]),
      .in_data   (data_bus[OFF_IN*W +: NC*W]),
      .in_sel    (sel_bus[k*SW +: SW]),
      .out_ctrl  (ctrl_bus[k+1]),
      .out_ready (rdy_bus[k+1]),
      .out_data  (data_bus[OFF_OUT*W +: (NC/2)*W]),
      .out_sel   (sel_bus[(k+1)*SW +: SW])
    );
  end

  // Every select bit is consumed by the last level; what remains is always zero.
  assign unused_sel = ^sel_bus[L*SW +: SW];

  assign out_valid = ctrl_bus[L].valid;
  assign out_err   = ctrl_bus[L].err;
  assign out_data  = data_bus[(BUS_WORDS-1)*W +: W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe at N_IN=5 (non-power-of-2, three levels):
// directed latency/stream/backpressure/bubble/reset phases plus randomized traffic.
module tb_mux_tree_pipe;

  localparam int N_IN = 5;
  localparam int W    = 8;
  localparam int SW   = $clog2(N_IN);
  localparam int L    = $clog2(N_IN);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN*W-1:0] in_data;
  logic [SW-1:0]     in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_err;

  mux_tree_pipe #(.N_IN(N_IN), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: pick word sel of the bank, or 0 when no such input exists.
  function automatic exp_t model(input logic [N_IN*W-1:0] d, input logic [SW-1:0] s);
    exp_t e;
    int   idx;
    idx    = int'(s);
    e.data = '0;
    if (idx < N_IN) e.data = d[idx*W +: W];
`ifdef MUX_TREE_PIPE_SEL_ERR_EN
    e.err = (idx >= N_IN);
`else
    e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat();
    for (int i = 0; i < N_IN; i++) in_data[i*W +: W] = W'($urandom);
    in_sel   = SW'($urandom_range((1 << SW) - 1));
    in_valid = 1'b1;
  endtask

  // Monitor: records accepted beats, checks emitted beats in order, checks stall stability.
  initial begin
    exp_t         e;
    logic         stall;
    logic [W-1:0] hd;
    logic         he;
    stall = 1'b0;
    hd    = '0;
    he    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(hd));
          chk("hold_err", 32'(out_err), 32'(he));
        end
        if (in_valid && in_ready) sb.push_back(model(in_data, in_sel));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got data %0h with no beat outstanding (t=%0t)", out_data, $time);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_err", 32'(out_err), 32'(e.err));
          end
        end
        stall = out_valid && !out_ready;
        hd    = out_data;
        he    = out_err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "tb_mux_tree_pipe timeout");
  end

  initial begin
    int   lat;
    int   acc;
    logic acc_now;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    // Latency: one beat into an empty pipe, bank 11,22,33,44,55, sel 2 -> 33.
    out_ready = 1'b1;
    for (int i = 0; i < N_IN; i++) in_data[i*W +: W] = W'((i + 1) * 8'h11);
    in_sel   = SW'(2);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= L + 4; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      tick();
    end
    chk("latency", 32'(lat), 32'(L));
    tick();

    // Streaming sweep with constant data: no input stall, no output bubble.
    for (int c = 0; c < N_IN + L; c++) begin
      if (c < N_IN) begin
        in_valid = 1'b1;
        in_sel   = SW'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < N_IN) chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (c >= L) chk("stream_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;

    // Backpressure: pipe fills with exactly L beats, then input stalls.
    out_ready = 1'b0;
    acc = 0;
    new_beat();
    for (int c = 0; c < L + 5; c++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      if (acc_now) acc++;
      tick();
      if (acc_now) new_beat();
    end
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(acc), 32'(L));
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (L + 2) tick();

    // Bubble collapse: A, idle, B while stalled; both leave back to back.
    out_ready = 1'b0;
    new_beat();
    @(negedge clk);
    chk("bubble_a_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    tick();
    new_beat();
    @(negedge clk);
    chk("bubble_b_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bubble_a_out", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bubble_b_out", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bubble_empty", 32'(out_valid), 32'd0);
    tick();

    // Edge selects: last real input and an out-of-range select.
    for (int k = 0; k < 2; k++) begin
      new_beat();
      in_sel = SW'((k == 0) ? N_IN - 1 : 6);
      tick();
    end
    in_valid = 1'b0;
    repeat (L + 2) tick();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid && ($urandom_range(99) < 70)) new_beat();
      out_ready = ($urandom_range(99) < 60);
      @(negedge clk);
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (L + 2) tick();
    @(negedge clk);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick();

    // Reset in the middle of a stalled, full pipe.
    out_ready = 1'b0;
    new_beat();
    for (int c = 0; c < L + 2; c++) begin
      @(negedge clk);
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) new_beat();
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_err", 32'(out_err), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(out_valid), 32'd0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
